mem_access_master: RTL and testbench

- Initiator side of the synchronous data-memory interface (address, rd, wr, write data, registered read data).
- Accepts one load/store request at a time from the core's execute stage and sequences the memory's single-port, 1-cycle-read-latency protocol.
- Sub-word stores use read-modify-write.
- Returns load data, sign- or zero-extended, plus an error flag on a one-cycle response pulse.

---
 rtl/mem_access_master.sv | 175 +++++++++++++++++
 tb/tb_mem_access_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_master.sv
// Load/store initiator for a single-port data memory with 1-cycle read latency; sub-word stores
// use read-modify-write. Optional macro MEM_RANGE_CHECK_EN flags out-of-range upper address bits.
`timescale 1ns/1ps
module mem_access_master #(
   parameter int unsigned DEPTH_W = 4,
   parameter int unsigned XLEN    = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_we_i,
   input  logic [1:0]      req_size_i,
   input  logic            req_unsigned_i,
   input  logic [XLEN-1:0] req_addr_i,
   input  logic [XLEN-1:0] req_wdata_i,
   output logic            rsp_valid_o,
   output logic [XLEN-1:0] rsp_rdata_o,
   output logic            rsp_err_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic            mem_rd_o,
   output logic            mem_wr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic [XLEN-1:0] mem_rdata_i
);

   // Byte-address bits that actually reach the memory.
   localparam int unsigned AW = DEPTH_W + 2;

   typedef enum logic [2:0] {StIdle, StRdIssue, StRdWait, StWr, StResp} state_e;

   state_e          state_q, state_d;
   logic            we_q, we_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
   logic            rsp_err_q, rsp_err_d;

   logic            addr_hi_nz;
   logic            range_err;
   logic            align_err;
   logic            req_err;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] merged;
   logic [XLEN-1:0] word_idx;

   assign addr_hi_nz = |req_addr_i[XLEN-1:AW];

`ifdef MEM_RANGE_CHECK_EN
   assign range_err = addr_hi_nz;
`else
   // Upper bits alias modulo the memory size.
   logic unused_addr_hi;
   assign unused_addr_hi = addr_hi_nz;
   assign range_err      = 1'b0;
`endif

   always_comb begin
      align_err = 1'b0;
      case (req_size_i)
         2'b00:   align_err = 1'b0;
         2'b01:   align_err = req_addr_i[0];
         2'b10:   align_err = |req_addr_i[1:0];
         default: align_err = 1'b1;
      endcase
   end

   assign req_err  = align_err | range_err;
   assign word_idx = XLEN'(addr_q[AW-1:2]);

   // Lane extraction and merge, little-endian lanes within the word.
   always_comb begin
      byte_sel  = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
      half_sel  = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
      load_data = mem_rdata_i;
      merged    = mem_rdata_i;
      case (size_q)
         2'b00: begin
            load_data = {{(XLEN-8){~uns_q & byte_sel[7]}}, byte_sel};
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         2'b01: begin
            load_data = {{(XLEN-16){~uns_q & half_sel[15]}}, half_sel};
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         default: begin
            load_data = mem_rdata_i;
            merged    = wdata_q;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               we_d        = req_we_i;
               size_d      = req_size_i;
               uns_d       = req_unsigned_i;
               addr_d      = req_addr_i[AW-1:0];
               wdata_d     = req_wdata_i;
               rsp_rdata_d = '0;
               rsp_err_d   = req_err;
               if (req_err) begin
                  state_d = StResp;
               end else if (req_we_i && req_size_i == 2'b10) begin
                  state_d = StWr;
               end else begin
                  state_d = StRdIssue;
               end
            end
         end
         StRdIssue: state_d = StRdWait;
         StRdWait: begin
            if (we_q) begin
               wdata_d = merged;
               state_d = StWr;
            end else begin
               rsp_rdata_d = load_data;
               state_d     = StResp;
            end
         end
         StWr:   state_d = StResp;
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Strobes decode straight from the state flop so reset drops them at once.
   always_comb begin
      req_ready_o = (state_q == StIdle);
      mem_rd_o    = (state_q == StRdIssue);
      mem_wr_o    = (state_q == StWr);
      rsp_valid_o = (state_q == StResp);
      mem_addr_o  = (mem_rd_o || mem_wr_o) ? word_idx : '0;
      mem_wdata_o = mem_wr_o ? wdata_q : '0;
      rsp_rdata_o = rsp_rdata_q;
      rsp_err_o   = rsp_err_q;
   end

endmodule

// File: tb/tb_mem_access_master.sv
// Directed self-checking bench for mem_access_master with a 16-word behavioural memory.
`timescale 1ns/1ps
module tb_mem_access_master;
   localparam int unsigned DEPTH_W = 4;
   localparam int unsigned XLEN    = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic            req_we = 1'b0;
   logic [1:0]      req_size = 2'b00;
   logic            req_unsigned = 1'b0;
   logic [XLEN-1:0] req_addr = '0;
   logic [XLEN-1:0] req_wdata = '0;
   logic            rsp_valid;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;
   logic [XLEN-1:0] mem_addr;
   logic            mem_rd;
   logic            mem_wr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_access_master #(.DEPTH_W(DEPTH_W), .XLEN(XLEN)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   // Behavioural memory: registered read, one-cycle latency; bench-side preload port.
   logic [31:0] mem [16];
   logic        pre_we = 1'b0;
   logic [3:0]  pre_idx = 4'd0;
   logic [31:0] pre_val = 32'd0;

   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_val;
      else if (mem_wr) mem[mem_addr[3:0]] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr[3:0]];
   end

   int          rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0, overlap_cnt = 0, idle_bus_cnt = 0;
   logic [31:0] last_wr_addr = '0, last_wr_data = '0, last_rd_addr = '0;

   always @(negedge clk) begin
      if (mem_rd) begin
         rd_cnt       <= rd_cnt + 1;
         last_rd_addr <= mem_addr;
      end
      if (mem_wr) begin
         wr_cnt       <= wr_cnt + 1;
         last_wr_addr <= mem_addr;
         last_wr_data <= mem_wdata;
      end
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
      if (mem_rd && mem_wr) overlap_cnt <= overlap_cnt + 1;
      if (!mem_rd && !mem_wr && (mem_addr != 0 || mem_wdata != 0))
         idle_bus_cnt <= idle_bus_cnt + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic preload(input int idx, input logic [31:0] val);
      @(negedge clk);
      pre_we  = 1'b1;
      pre_idx = idx[3:0];
      pre_val = val;
      @(negedge clk);
      pre_we  = 1'b0;
   endtask

   // Issues one request and returns at #1 after the edge where rsp_valid rose.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err);
      int w;
      @(negedge clk);
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         n_checks++; n_fail++;
         $display("FAIL req_ready_timeout: req_ready=%0b required 1", req_ready);
      end
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      // Scramble inputs: the latched copy must be used from here on.
      req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
      req_addr = ~addr; req_wdata = ~wdata;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!rsp_valid) begin
         n_checks++; n_fail++;
         $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
         lat = 99;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", req_ready); end
      n_checks++; if ({rsp_valid, rsp_err, mem_rd, mem_wr} !== 4'b0000) begin n_fail++; $display("FAIL rst_strobes: got %b want 0000", {rsp_valid, rsp_err, mem_rd, mem_wr}); end
      n_checks++; if ({rsp_rdata, mem_addr, mem_wdata} !== 96'd0) begin n_fail++; $display("FAIL rst_data: rdata=%h addr=%h wdata=%h want 0", rsp_rdata, mem_addr, mem_wdata); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_word_store_load();
      int lat; logic [31:0] rd; logic err; int rd0, wr0;
      preload(2, 32'h0);
      rd0 = rd_cnt; wr0 = wr_cnt;
      do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, lat, rd, err);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wst_lat: got %0d want 2", lat); end
      n_checks++; if ({err, rd} !== 33'd0) begin n_fail++; $display("FAIL wst_rsp: err=%0b rdata=%h want 0/0", err, rd); end
      n_checks++; if (wr_cnt - wr0 !== 1 || rd_cnt - rd0 !== 0) begin n_fail++; $display("FAIL wst_strobes: wr=%0d rd=%0d want 1/0", wr_cnt - wr0, rd_cnt - rd0); end
      n_checks++; if (last_wr_addr !== 32'd2 || last_wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wst_bus: addr=%h data=%h want 2/deadbeef", last_wr_addr, last_wr_data); end
      do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, err);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wld_lat: got %0d want 3", lat); end
      n_checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin n_fail++; $display("FAIL wld_data: got %h err=%0b want deadbeef/0", rd, err); end
   endtask

   task automatic test_subword_store();
      int lat; logic [31:0] rd; logic err; int rd0, wr0;
      preload(2, 32'h11223344);
      rd0 = rd_cnt; wr0 = wr_cnt;
      do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h123456AA, lat, rd, err);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL bst_lat: got %0d want 4", lat); end
      n_checks++; if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 1) begin n_fail++; $display("FAIL bst_strobes: rd=%0d wr=%0d want 1/1", rd_cnt - rd0, wr_cnt - wr0); end
      n_checks++; if (last_wr_data !== 32'h1122AA44 || last_wr_addr !== 32'd2) begin n_fail++; $display("FAIL bst_merge: data=%h addr=%h want 1122aa44/2", last_wr_data, last_wr_addr); end
      n_checks++; if (mem[2] !== 32'h1122AA44) begin n_fail++; $display("FAIL bst_mem: got %h want 1122aa44", mem[2]); end
      preload(3, 32'h01234567);
      do_req(1'b1, 2'b01, 1'b0, 32'hE, 32'h0000BEEF, lat, rd, err);
      n_checks++; if (mem[3] !== 32'hBEEF4567 || err !== 1'b0) begin n_fail++; $display("FAIL hst_merge: got %h err=%0b want beef4567/0", mem[3], err); end
   endtask

   task automatic test_loads();
      int lat; logic [31:0] rd; logic err;
      logic [31:0] addrs [6];
      logic [1:0]  sizes [6];
      logic        unss  [6];
      logic [31:0] exps  [6];
      addrs = '{32'h8, 32'h8, 32'hA, 32'h9, 32'hB, 32'h8};
      sizes = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
      unss  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      exps  = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8000, 32'hFFFFFFF0, 32'hFFFFFF80, 32'h0000F0FF};
      preload(2, 32'h8000F0FF);
      for (int i = 0; i < 6; i++) begin
         do_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0, lat, rd, err);
         n_checks++;
         if (rd !== exps[i] || err !== 1'b0 || lat !== 3) begin
            n_fail++;
            $display("FAIL load_%0d: rdata=%h err=%0b lat=%0d want %h/0/3", i, rd, err, lat, exps[i]);
         end
      end
   endtask

   task automatic test_errors();
      int lat; logic [31:0] rd; logic err; int rd0, wr0;
      logic [31:0] addrs [3];
      logic [1:0]  sizes [3];
      logic        wes   [3];
      addrs = '{32'h3, 32'h8, 32'h2};
      sizes = '{2'b01, 2'b11, 2'b10};
      wes   = '{1'b0, 1'b1, 1'b1};
      rd0 = rd_cnt; wr0 = wr_cnt;
      for (int i = 0; i < 3; i++) begin
         do_req(wes[i], sizes[i], 1'b0, addrs[i], 32'hFFFFFFFF, lat, rd, err);
         n_checks++;
         if (err !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            n_fail++;
            $display("FAIL err_%0d: err=%0b rdata=%h lat=%0d want 1/0/1", i, err, rd, lat);
         end
      end
      n_checks++; if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 0) begin n_fail++; $display("FAIL err_noaccess: rd=%0d wr=%0d want 0/0", rd_cnt - rd0, wr_cnt - wr0); end
      repeat (2) @(negedge clk);
      n_checks++; if (rsp_err !== 1'b1 || req_ready !== 1'b1) begin n_fail++; $display("FAIL err_hold: err=%0b ready=%0b want 1/1", rsp_err, req_ready); end
   endtask

   task automatic test_range();
      int lat; logic [31:0] rd; logic err; int rd0;
      rd0 = rd_cnt;
      do_req(1'b0, 2'b10, 1'b0, 32'h48, 32'h0, lat, rd, err);
`ifdef MEM_RANGE_CHECK_EN
      n_checks++; if (err !== 1'b1 || lat !== 1 || rd_cnt - rd0 !== 0) begin n_fail++; $display("FAIL range: err=%0b lat=%0d rd=%0d want 1/1/0", err, lat, rd_cnt - rd0); end
`else
      n_checks++; if (err !== 1'b0 || rd !== 32'h8000F0FF || last_rd_addr !== 32'd2 || rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL range: err=%0b rdata=%h addr=%h want 0/8000f0ff/2", err, rd, last_rd_addr); end
`endif
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; logic err; int wr0, rsp0;
      preload(4, 32'h55667788);
      wr0 = wr_cnt; rsp0 = rsp_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h10; req_wdata = 32'h99;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_checks++; if ({mem_rd, mem_wr, rsp_valid, req_ready} !== 4'b0001) begin n_fail++; $display("FAIL mid_strobes: rd/wr/vld/rdy=%b want 0001", {mem_rd, mem_wr, rsp_valid, req_ready}); end
      n_checks++; if ({mem_addr, mem_wdata, rsp_rdata} !== 96'd0) begin n_fail++; $display("FAIL mid_data: addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, rsp_rdata); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (wr_cnt - wr0 !== 0 || rsp_cnt - rsp0 !== 0) begin n_fail++; $display("FAIL mid_abort: wr=%0d rsp=%0d want 0/0", wr_cnt - wr0, rsp_cnt - rsp0); end
      n_checks++; if (mem[4] !== 32'h55667788) begin n_fail++; $display("FAIL mid_mem: got %h want 55667788", mem[4]); end
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, err);
      n_checks++; if (rd !== 32'h55667788 || err !== 1'b0 || lat !== 3) begin n_fail++; $display("FAIL mid_next: rdata=%h err=%0b lat=%0d want 55667788/0/3", rd, err, lat); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] rd; logic err;
      do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEF00D, lat, rd, err);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL b2b_st_lat: got %0d want 2", lat); end
      // Present the next request while still in RESP; it is taken on the edge after IDLE.
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h4; req_wdata = 32'h0;
      @(posedge clk); #1;
      n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: ready=%0b vld=%0b want 1/0", req_ready, rsp_valid); end
      @(posedge clk); #1;
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: ready=%0b want 0", req_ready); end
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      n_checks++; if (lat !== 3 || rsp_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_load: lat=%0d rdata=%h want 3/cafef00d", lat, rsp_rdata); end
   endtask

   task automatic test_bus_rules();
      @(negedge clk); #1;
      n_checks++; if (overlap_cnt !== 0) begin n_fail++; $display("FAIL rd_wr_overlap: got %0d want 0", overlap_cnt); end
      n_checks++; if (idle_bus_cnt !== 0) begin n_fail++; $display("FAIL idle_bus_nonzero: got %0d want 0", idle_bus_cnt); end
   endtask

   initial begin
      test_reset();
      test_word_store_load();
      test_subword_store();
      test_loads();
      test_errors();
      test_range();
      test_reset_mid();
      test_back_to_back();
      test_bus_rules();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
